// File: rtl/rcc_dx_wkup_seq.sv
// Power-domain wakeup/sleep sequencer: oscillator request, clock enable,
// timed reset release and ordered shutdown for domains D1..D3.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a pending wakeup (first) or a sleep request
// OSC_WAIT | oscillator requested, waiting for osc_rdy or timeout
// CLK_ON   | domain clock enabled, reset held for RST_HOLD_CYC cycles
// REL      | domain reset released, one cycle
// SLP_RST  | domain reset asserted
// SLP_GATE | domain clock gated
module rcc_dx_wkup_seq #(
  parameter int SYNC_STAGES  = 2,
  parameter int OSC_TO_CYC   = 1024,
  parameter int RST_HOLD_CYC = 16
) (
  input  logic       hsi_origin_clk,
  input  logic       rcc_rst,
  input  logic       pwr_d1_wkup,
  input  logic       pwr_d2_wkup,
  input  logic       pwr_d3_wkup,
  input  logic [2:0] sleep_req,
  input  logic       osc_rdy,
  input  logic       clr_err,
  output logic       osc_en,
  output logic [2:0] dom_clk_en,
  output logic [2:0] dom_rst_n,
  output logic       busy,
  output logic [2:0] timeout_err
);

  localparam int TW = $clog2(OSC_TO_CYC + 1);
  localparam int HW = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OSC_WAIT = 3'd1,
    CLK_ON   = 3'd2,
    REL      = 3'd3,
    SLP_RST  = 3'd4,
    SLP_GATE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    sync_q [SYNC_STAGES];
  logic [6:0]    raw;
  logic [2:0]    wkup_s, slp_s;
  logic          rdy_s;
  logic [2:0]    wkup_d, rise, pending, slp_act;
  logic [2:0]    cur_q, sel, tgt, pend_clr, to_set;
  logic [TW-1:0] to_cnt;
  logic [HW-1:0] hold_cnt;
  logic          enter_wait, enter_clk, enter_rel, enter_slp, leave_idle;

  // Arbitration order D3 > D1 > D2, returned one-hot.
  function automatic logic [2:0] pick(input logic [2:0] v);
    if (v[2])      return 3'b100;
    else if (v[0]) return 3'b001;
    else if (v[1]) return 3'b010;
    else           return 3'b000;
  endfunction

  assign raw = {osc_rdy, sleep_req, pwr_d3_wkup, pwr_d2_wkup, pwr_d1_wkup};

  always_ff @(posedge hsi_origin_clk) begin
    if (rcc_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {rdy_s, slp_s, wkup_s} = sync_q[SYNC_STAGES-1];
  assign rise    = wkup_s & ~wkup_d;
  assign slp_act = slp_s & dom_rst_n;

  always_ff @(posedge hsi_origin_clk) begin
    if (rcc_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|pending)      state_d = rdy_s ? CLK_ON : OSC_WAIT;
        else if (|slp_act) state_d = SLP_RST;
      end
      OSC_WAIT: begin
        if (rdy_s)              state_d = CLK_ON;
        else if (to_cnt == '0)  state_d = IDLE;
      end
      CLK_ON:   if (hold_cnt == '0) state_d = REL;
      REL:      state_d = IDLE;
      SLP_RST:  state_d = SLP_GATE;
      SLP_GATE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // In IDLE the target domain is still being chosen, so use the arbiter pick.
  always_comb begin
    sel        = (|pending) ? pick(pending) : pick(slp_act);
    tgt        = (state_q == IDLE) ? sel : cur_q;
    leave_idle = (state_q == IDLE) && (state_d != IDLE);
    pend_clr   = ((state_q == IDLE) && (|pending)) ? sel : 3'b000;
    enter_wait = (state_q == IDLE) && (state_d == OSC_WAIT);
    enter_clk  = (state_q != CLK_ON) && (state_d == CLK_ON);
    enter_rel  = (state_q == CLK_ON) && (state_d == REL);
    enter_slp  = (state_q == IDLE) && (state_d == SLP_RST);
    to_set     = ((state_q == OSC_WAIT) && !rdy_s && (to_cnt == '0)) ? cur_q : 3'b000;
    busy       = (state_q != IDLE);
    osc_en     = (|dom_rst_n) || (state_q == OSC_WAIT) || (state_q == CLK_ON);
  end

  always_ff @(posedge hsi_origin_clk) begin
    if (rcc_rst) begin
      wkup_d      <= '0;
      pending     <= '0;
      cur_q       <= '0;
      to_cnt      <= '0;
      hold_cnt    <= '0;
      dom_clk_en  <= '0;
      dom_rst_n   <= '0;
      timeout_err <= '0;
    end else begin
      wkup_d  <= wkup_s;
      // A wakeup for a domain that is already running is dropped.
      pending <= ((pending & ~pend_clr) | rise) & ~dom_rst_n;
      if (leave_idle) cur_q <= sel;

      if (enter_wait)
        to_cnt <= TW'(OSC_TO_CYC);
      else if ((state_q == OSC_WAIT) && (to_cnt != '0))
        to_cnt <= to_cnt - TW'(1);

      if (enter_clk)
        hold_cnt <= HW'(RST_HOLD_CYC - 1);
      else if ((state_q == CLK_ON) && (hold_cnt != '0))
        hold_cnt <= hold_cnt - HW'(1);

      dom_clk_en  <= (dom_clk_en | (enter_clk ? tgt : 3'b000))
                     & ~((state_q == SLP_RST) ? cur_q : 3'b000);
      dom_rst_n   <= (dom_rst_n | (enter_rel ? cur_q : 3'b000))
                     & ~(enter_slp ? tgt : 3'b000);
      // A timeout in the same cycle as clr_err still lands.
      timeout_err <= (timeout_err & ~{3{clr_err}}) | to_set;
    end
  end

endmodule

// File: tb/tb_rcc_dx_wkup_seq.sv
// Self-checking bench for rcc_dx_wkup_seq: directed scenarios plus randomized
// wake/sleep sequences compared against a timing model of the sequencer.
module tb_rcc_dx_wkup_seq;

  localparam int SYNC    = 2;
  localparam int TO      = 1024;
  localparam int HOLD    = 16;
  localparam int CLK_LAT = SYNC + 2;
  localparam int WK_LAT  = CLK_LAT + HOLD;
  localparam int SLP_LAT = SYNC + 1;
  localparam int SEP     = HOLD + 2;

  logic       clk = 1'b0;
  logic       rcc_rst = 1'b1;
  logic       d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
  logic [2:0] sleep_req = '0;
  logic       osc_rdy = 1'b0;
  logic       clr_err = 1'b0;
  logic       osc_en, busy;
  logic [2:0] dom_clk_en, dom_rst_n, timeout_err;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  logic [2:0] model_act = '0;

  int   rst_rise_t[3], rst_fall_t[3], clk_rise_t[3], clk_fall_t[3];
  logic [2:0] rn_p = '0, ce_p = '0;
  logic busy_seen = 1'b0;

  rcc_dx_wkup_seq #(.SYNC_STAGES(SYNC), .OSC_TO_CYC(TO), .RST_HOLD_CYC(HOLD)) dut (
    .hsi_origin_clk(clk),
    .rcc_rst       (rcc_rst),
    .pwr_d1_wkup   (d1),
    .pwr_d2_wkup   (d2),
    .pwr_d3_wkup   (d3),
    .sleep_req     (sleep_req),
    .osc_rdy       (osc_rdy),
    .clr_err       (clr_err),
    .osc_en        (osc_en),
    .dom_clk_en    (dom_clk_en),
    .dom_rst_n     (dom_rst_n),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge recorder: cycle number of the clock edge that changed each output.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (dom_rst_n[d] && !rn_p[d])  rst_rise_t[d] = cyc;
      if (!dom_rst_n[d] && rn_p[d])  rst_fall_t[d] = cyc;
      if (dom_clk_en[d] && !ce_p[d]) clk_rise_t[d] = cyc;
      if (!dom_clk_en[d] && ce_p[d]) clk_fall_t[d] = cyc;
    end
    if (busy) busy_seen = 1'b1;
    rn_p = dom_rst_n;
    ce_p = dom_clk_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_wkup(input logic [2:0] m);
    {d3, d2, d1} = m;
  endtask

  task automatic clear_marks();
    for (int d = 0; d < 3; d++) begin
      rst_rise_t[d] = -1; rst_fall_t[d] = -1;
      clk_rise_t[d] = -1; clk_fall_t[d] = -1;
    end
    busy_seen = 1'b0;
  endtask

  task automatic do_reset();
    rcc_rst = 1'b1;
    drive_wkup(3'b000);
    sleep_req = '0;
    clr_err = 1'b0;
    tick(2);
    rcc_rst = 1'b0;
    model_act = '0;
    tick(1);
  endtask

  // gap == 0: oscillator already ready; otherwise osc_rdy rises gap cycles after the pulse ends.
  task automatic wake_dom(input int d, input int gap, output int exp_clk, output int exp_rel,
                          output logic mid_osc_en);
    int c0;
    osc_rdy = (gap == 0);
    tick(SYNC + 2);
    clear_marks();
    c0 = cyc;
    drive_wkup(3'b001 << d);
    tick(3);
    drive_wkup(3'b000);
    mid_osc_en = 1'b0;
    if (gap == 0) begin
      exp_clk = c0 + CLK_LAT;
    end else begin
      tick(gap);
      mid_osc_en = osc_en;
      exp_clk = cyc + SYNC + 1;
      osc_rdy = 1'b1;
    end
    exp_rel = exp_clk + HOLD;
    tick(exp_rel - cyc + 3);
    model_act[d] = 1'b1;
  endtask

  task automatic sleep_dom(input int d, output int exp_rf, output int exp_cf);
    int c0;
    clear_marks();
    c0 = cyc;
    sleep_req[d] = 1'b1;
    exp_rf = c0 + SLP_LAT;
    exp_cf = exp_rf + 1;
    tick(SLP_LAT + 3);
    sleep_req[d] = 1'b0;
    tick(SYNC + 2);
    model_act[d] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    d1 = 1'b1;
    osc_rdy = 1'b1;
    tick(4);
    chk_cnt++; if (osc_en !== 1'b0) $display("FAIL reset_osc_en: got %b expected 0", osc_en); else pass_cnt++;
    chk_cnt++; if (dom_clk_en !== 3'b000) $display("FAIL reset_clk_en: got %b expected 000", dom_clk_en); else pass_cnt++;
    chk_cnt++; if (dom_rst_n !== 3'b000) $display("FAIL reset_rst_n: got %b expected 000", dom_rst_n); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (timeout_err !== 3'b000) $display("FAIL reset_err: got %b expected 000", timeout_err); else pass_cnt++;
    d1 = 1'b0;
    rcc_rst = 1'b0;
    tick(SYNC + 3);
    chk_cnt++; if (busy !== 1'b0 || dom_rst_n !== 3'b000)
      $display("FAIL reset_release_quiet: got busy=%b rst_n=%b expected 0/000", busy, dom_rst_n); else pass_cnt++;
  endtask

  task automatic test_wakeup_d1();
    int ec, er; logic mo;
    wake_dom(0, 0, ec, er, mo);
    chk_cnt++; if (er - ec + CLK_LAT !== 20) $display("FAIL d1_model_latency: got %0d expected 20", er - ec + CLK_LAT); else pass_cnt++;
    chk_cnt++; if (clk_rise_t[0] !== ec) $display("FAIL d1_clk_en_time: got %0d expected %0d", clk_rise_t[0], ec); else pass_cnt++;
    chk_cnt++; if (rst_rise_t[0] !== er) $display("FAIL d1_release_time: got %0d expected %0d", rst_rise_t[0], er); else pass_cnt++;
    chk_cnt++; if (osc_en !== 1'b1) $display("FAIL d1_osc_en: got %b expected 1", osc_en); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL d1_busy_after: got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (dom_rst_n !== model_act) $display("FAIL d1_rst_n: got %b expected %b", dom_rst_n, model_act); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int c0, t; logic found;
    osc_rdy = 1'b0;
    tick(SYNC + 2);
    clear_marks();
    c0 = cyc;
    d2 = 1'b1; tick(3); d2 = 1'b0;
    tick(c0 + 500 - cyc);
    chk_cnt++; if (osc_en !== 1'b1 || busy !== 1'b1)
      $display("FAIL to_wait_state: got osc_en=%b busy=%b expected 1/1", osc_en, busy); else pass_cnt++;
    found = 1'b0; t = 0;
    while (!found && cyc < c0 + TO + 200) begin
      tick(1);
      if (timeout_err !== 3'b000) begin found = 1'b1; t = cyc; end
    end
    chk_cnt++; if (!found) $display("FAIL to_seen: got none expected timeout within %0d cycles", TO + 200); else pass_cnt++;
    chk_cnt++; if (timeout_err !== 3'b010) $display("FAIL to_err_value: got %b expected 010", timeout_err); else pass_cnt++;
    chk_cnt++; if (t - c0 < TO || t - c0 > TO + SYNC + 4)
      $display("FAIL to_time: got %0d expected %0d..%0d", t - c0, TO, TO + SYNC + 4); else pass_cnt++;
    tick(1);
    chk_cnt++; if (dom_rst_n[1] !== 1'b0 || dom_clk_en[1] !== 1'b0 || clk_rise_t[1] !== -1)
      $display("FAIL to_dom_off: got rst_n=%b clk_en=%b expected 0/0", dom_rst_n[1], dom_clk_en[1]); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL to_busy: got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (osc_en !== (model_act != 3'b000)) $display("FAIL to_osc_en: got %b expected %b", osc_en, model_act != 3'b000); else pass_cnt++;
    clr_err = 1'b1; tick(1); clr_err = 1'b0; tick(1);
    chk_cnt++; if (timeout_err !== 3'b000) $display("FAIL to_clr: got %b expected 000", timeout_err); else pass_cnt++;
  endtask

  task automatic test_err_set_wins();
    int c0; logic found;
    osc_rdy = 1'b0;
    tick(SYNC + 2);
    clr_err = 1'b1;
    c0 = cyc;
    d3 = 1'b1; tick(3); d3 = 1'b0;
    found = 1'b0;
    while (!found && cyc < c0 + TO + 200) begin
      tick(1);
      if (timeout_err !== 3'b000) found = 1'b1;
    end
    chk_cnt++; if (!found) $display("FAIL setwins_seen: got none expected 100 despite clr_err"); else pass_cnt++;
    chk_cnt++; if (timeout_err !== 3'b100) $display("FAIL setwins_value: got %b expected 100", timeout_err); else pass_cnt++;
    tick(1);
    chk_cnt++; if (timeout_err !== 3'b000) $display("FAIL setwins_then_clr: got %b expected 000", timeout_err); else pass_cnt++;
    clr_err = 1'b0;
  endtask

  task automatic test_simultaneous();
    int c0;
    do_reset();
    osc_rdy = 1'b1;
    tick(SYNC + 2);
    clear_marks();
    c0 = cyc;
    drive_wkup(3'b111); tick(3); drive_wkup(3'b000);
    tick(WK_LAT + 2 * SEP + 5);
    chk_cnt++; if (rst_rise_t[2] !== c0 + WK_LAT) $display("FAIL simul_d3: got %0d expected %0d", rst_rise_t[2] - c0, WK_LAT); else pass_cnt++;
    chk_cnt++; if (rst_rise_t[0] !== c0 + WK_LAT + SEP) $display("FAIL simul_d1: got %0d expected %0d", rst_rise_t[0] - c0, WK_LAT + SEP); else pass_cnt++;
    chk_cnt++; if (rst_rise_t[1] !== c0 + WK_LAT + 2 * SEP) $display("FAIL simul_d2: got %0d expected %0d", rst_rise_t[1] - c0, WK_LAT + 2 * SEP); else pass_cnt++;
    chk_cnt++; if (dom_rst_n !== 3'b111 || busy !== 1'b0)
      $display("FAIL simul_final: got rst_n=%b busy=%b expected 111/0", dom_rst_n, busy); else pass_cnt++;
    model_act = 3'b111;
  endtask

  task automatic test_sleep();
    int rf, cf;
    int order[3] = '{0, 2, 1};
    foreach (order[k]) begin
      sleep_dom(order[k], rf, cf);
      chk_cnt++; if (rst_fall_t[order[k]] !== rf) $display("FAIL sleep_rst_fall_d%0d: got %0d expected %0d", order[k] + 1, rst_fall_t[order[k]], rf); else pass_cnt++;
      chk_cnt++; if (clk_fall_t[order[k]] !== cf) $display("FAIL sleep_clk_fall_d%0d: got %0d expected %0d", order[k] + 1, clk_fall_t[order[k]], cf); else pass_cnt++;
      chk_cnt++; if (osc_en !== (model_act != 3'b000)) $display("FAIL sleep_osc_en_d%0d: got %b expected %b", order[k] + 1, osc_en, model_act != 3'b000); else pass_cnt++;
      chk_cnt++; if (dom_clk_en !== model_act) $display("FAIL sleep_clk_en_d%0d: got %b expected %b", order[k] + 1, dom_clk_en, model_act); else pass_cnt++;
    end
  endtask

  task automatic test_sleep_wkup_same();
    int ec, er, c0; logic mo;
    wake_dom(0, 0, ec, er, mo);
    chk_cnt++; if (rst_rise_t[0] !== er) $display("FAIL same_pre_wake: got %0d expected %0d", rst_rise_t[0], er); else pass_cnt++;
    clear_marks();
    c0 = cyc;
    sleep_req[0] = 1'b1; d1 = 1'b1;
    tick(3); d1 = 1'b0;
    tick(10); sleep_req[0] = 1'b0;
    tick(WK_LAT + 5);
    model_act[0] = 1'b0;
    chk_cnt++; if (rst_fall_t[0] !== c0 + SLP_LAT) $display("FAIL same_sleep_served: got %0d expected %0d", rst_fall_t[0], c0 + SLP_LAT); else pass_cnt++;
    chk_cnt++; if (rst_rise_t[0] !== -1 || dom_rst_n[0] !== 1'b0)
      $display("FAIL same_wkup_ignored: got rise=%0d rst_n=%b expected -1/0", rst_rise_t[0], dom_rst_n[0]); else pass_cnt++;
    wake_dom(0, $urandom_range(2, 40), ec, er, mo);
    chk_cnt++; if (rst_rise_t[0] !== er) $display("FAIL same_rewake: got %0d expected %0d", rst_rise_t[0], er); else pass_cnt++;
    chk_cnt++; if (mo !== 1'b1) $display("FAIL same_rewake_osc_wait: got %b expected 1", mo); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int c0, ec, er; logic mo;
    osc_rdy = 1'b1;
    tick(SYNC + 2);
    clear_marks();
    c0 = cyc;
    d2 = 1'b1; tick(3); d2 = 1'b0;
    tick(c0 + 10 - cyc);
    chk_cnt++; if (dom_clk_en[1] !== 1'b1 || dom_rst_n[1] !== 1'b0)
      $display("FAIL mid_clk_on: got clk_en=%b rst_n=%b expected 1/0", dom_clk_en[1], dom_rst_n[1]); else pass_cnt++;
    rcc_rst = 1'b1; tick(1); rcc_rst = 1'b0;
    model_act = '0;
    chk_cnt++; if ({osc_en, dom_clk_en, dom_rst_n, busy, timeout_err} !== 11'b0)
      $display("FAIL mid_reset_vals: got osc=%b clk=%b rst=%b busy=%b err=%b expected all 0",
               osc_en, dom_clk_en, dom_rst_n, busy, timeout_err); else pass_cnt++;
    tick(25);
    chk_cnt++; if (rst_rise_t[1] !== -1 || dom_rst_n !== 3'b000)
      $display("FAIL mid_no_partial: got rise=%0d rst_n=%b expected -1/000", rst_rise_t[1], dom_rst_n); else pass_cnt++;
    wake_dom(1, 0, ec, er, mo);
    chk_cnt++; if (rst_rise_t[1] !== er || clk_rise_t[1] !== ec)
      $display("FAIL mid_repeat: got rel=%0d clk=%0d expected %0d/%0d", rst_rise_t[1], clk_rise_t[1], er, ec); else pass_cnt++;
  endtask

  task automatic test_rewake_active();
    int ec, er; logic mo;
    wake_dom(2, 0, ec, er, mo);
    chk_cnt++; if (rst_rise_t[2] !== er) $display("FAIL rewake_first: got %0d expected %0d", rst_rise_t[2], er); else pass_cnt++;
    clear_marks();
    d3 = 1'b1; tick(3); d3 = 1'b0;
    tick(25);
    chk_cnt++; if (busy_seen !== 1'b0) $display("FAIL rewake_busy: got %b expected 0", busy_seen); else pass_cnt++;
    chk_cnt++; if (rst_fall_t[2] !== -1 || dom_rst_n !== model_act)
      $display("FAIL rewake_glitch: got fall=%0d rst_n=%b expected -1/%b", rst_fall_t[2], dom_rst_n, model_act); else pass_cnt++;
  endtask

  task automatic test_random();
    int d, gap, ec, er, rf, cf; logic mo;
    for (int it = 0; it < 16; it++) begin
      d = $urandom_range(0, 2);
      tick($urandom_range(0, 5));
      if (model_act[d]) begin
        sleep_dom(d, rf, cf);
        chk_cnt++; if (rst_fall_t[d] !== rf || clk_fall_t[d] !== cf)
          $display("FAIL rand_sleep_%0d: got %0d/%0d expected %0d/%0d", it, rst_fall_t[d], clk_fall_t[d], rf, cf); else pass_cnt++;
      end else begin
        gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 60);
        wake_dom(d, gap, ec, er, mo);
        chk_cnt++; if (rst_rise_t[d] !== er || clk_rise_t[d] !== ec)
          $display("FAIL rand_wake_%0d: got %0d/%0d expected %0d/%0d", it, rst_rise_t[d], clk_rise_t[d], er, ec); else pass_cnt++;
        if (gap != 0) begin
          chk_cnt++; if (mo !== 1'b1) $display("FAIL rand_osc_wait_%0d: got %b expected 1", it, mo); else pass_cnt++;
        end
      end
      chk_cnt++; if (dom_rst_n !== model_act || dom_clk_en !== model_act || osc_en !== (model_act != 3'b000) || busy !== 1'b0)
        $display("FAIL rand_state_%0d: got rst=%b clk=%b osc=%b busy=%b expected %b/%b/%b/0",
                 it, dom_rst_n, dom_clk_en, osc_en, busy, model_act, model_act, model_act != 3'b000); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_wakeup_d1();
    test_timeout();
    test_err_set_wins();
    test_simultaneous();
    test_sleep();
    test_sleep_wkup_same();
    test_reset_mid();
    test_rewake_active();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
